// File: rtl/alu_pkg.sv
// Shared opcode, FSM state encoding and opcode-class helpers for the EX-stage ALU.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_LUI    = 5'd10,
    OP_JALR   = 5'd11,
    OP_CSR    = 5'd12,
    OP_MUL    = 5'd13,
    OP_MULH   = 5'd14,
    OP_MULHSU = 5'd15,
    OP_MULHU  = 5'd16,
    OP_DIV    = 5'd17,
    OP_DIVU   = 5'd18,
    OP_REM    = 5'd19,
    OP_REMU   = 5'd20
  } alu_op_e;

  typedef logic [1:0] state_e;

  localparam state_e ST_IDLE = 2'd0;
  localparam state_e ST_MUL  = 2'd1;
  localparam state_e ST_DIV  = 2'd2;
  localparam state_e ST_DONE = 2'd3;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMU);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMU);
  endfunction

  function automatic logic is_rem(input logic [4:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_mulh(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

  function automatic logic is_signed_src1(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_src2(input logic [4:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 shift-add multiplier / restoring divider on operand magnitudes,
// with the sign fix-up applied to the final step so the result is ready with done_c.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done_c,
  output logic [XLEN-1:0] result_c
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  logic              active;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_mag_q;
  logic              div_mode, sel_hi, neg_q, neg_r;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   quo, rem;

  // Operand magnitudes at start, per signedness of the op
  always_comb begin
    a_neg = is_signed_src1(op) & a[XLEN-1];
    b_neg = is_signed_src2(op) & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration: {hi,lo} holds product/multiplier or remainder/quotient
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag_q} : {(XLEN+1){1'b0}});
    div_sh   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_sh - {1'b0, b_mag_q};
    if (!div_mode)
      acc_step = {mul_sum, acc[XLEN-1:1]};
    else if (div_diff[XLEN])
      acc_step = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  end

  always_comb begin
    done_c = active && (cnt == CW'(XLEN - 1));
    prod   = neg_q ? -acc_step : acc_step;
    quo    = acc_step[XLEN-1:0];
    rem    = acc_step[2*XLEN-1:XLEN];
    if (!div_mode)
      result_c = sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    else if (sel_hi)
      result_c = neg_r ? -rem : rem;
    else
      result_c = neg_q ? -quo : quo;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      b_mag_q  <= '0;
      div_mode <= 1'b0;
      sel_hi   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (flush) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= '0;
      acc      <= {{XLEN{1'b0}}, a_mag};
      b_mag_q  <= b_mag;
      div_mode <= is_div(op);
      sel_hi   <= is_rem(op) || is_mulh(op);
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
    end else if (active) begin
      acc <= acc_step;
      cnt <= cnt + CW'(1);
      if (done_c) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage ALU: single-cycle base ops inline, RV32M ops on the iterative engine,
// valid/ready on both sides so the pipeline can stall on long operations.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] pcadd4,
  input  logic [XLEN-1:0] csr_src,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  state_e          state, state_n;
  logic [XLEN-1:0] result_n, base_res, spec_res, eng_result_c;
  logic [SHW-1:0]  shamt;
  logic            accept_c, start_c, special_c, div_zero, div_ovf, eng_done_c;

  // Single-cycle base operations
  always_comb begin
    shamt    = src2[SHW-1:0];
    base_res = '0;
    case (alu_op)
      OP_ADD:  base_res = src1 + src2;
      OP_SUB:  base_res = src1 - src2;
      OP_SLL:  base_res = src1 << shamt;
      OP_SLT:  base_res = XLEN'($signed(src1) < $signed(src2));
      OP_SLTU: base_res = XLEN'(src1 < src2);
      OP_XOR:  base_res = src1 ^ src2;
      OP_SRL:  base_res = src1 >> shamt;
      OP_SRA:  base_res = $unsigned($signed(src1) >>> shamt);
      OP_OR:   base_res = src1 | src2;
      OP_AND:  base_res = src1 & src2;
      OP_LUI:  base_res = src2;
      OP_JALR: base_res = pcadd4;
      OP_CSR:  base_res = csr_src;
      default: base_res = '0;
    endcase
  end

  // Divide-by-zero and signed overflow resolve without iterating
  always_comb begin
    div_zero  = is_div(alu_op) && (src2 == '0);
    div_ovf   = ((alu_op == OP_DIV) || (alu_op == OP_REM)) &&
                (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
    special_c = div_zero || div_ovf;
    if (div_zero)
      spec_res = is_rem(alu_op) ? src1 : '1;
    else
      spec_res = is_rem(alu_op) ? '0 : src1;
  end

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept_c = in_valid && in_ready && !flush;
  assign start_c  = accept_c && is_muldiv(alu_op) && !special_c;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_c),
    .flush    (flush),
    .op       (alu_op),
    .a        (src1),
    .b        (src2),
    .done_c   (eng_done_c),
    .result_c (eng_result_c)
  );

  always_comb begin
    state_n  = state;
    result_n = result;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (accept_c) begin
          if (start_c) begin
            state_n = is_div(alu_op) ? ST_DIV : ST_MUL;
          end else begin
            state_n  = ST_DONE;
            result_n = special_c ? spec_res : base_res;
          end
        end else if ((state == ST_DONE) && out_ready) begin
          state_n = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (eng_done_c) begin
          state_n  = ST_DONE;
          result_n = eng_result_c;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      result    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      result    <= result_n;
      out_valid <= (state_n == ST_DONE);
      busy      <= (state_n == ST_MUL) || (state_n == ST_DIV);
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at XLEN=32.
module tb_alu_muldiv;
  import alu_pkg::*;

  logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
  logic [4:0]  alu_op;
  logic [31:0] src1, src2, pcadd4, csr_src, result;
  int          checks, errors;

  alu_muldiv #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .src1      (src1),
    .src2      (src2),
    .pcadd4    (pcadd4),
    .csr_src   (csr_src),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one op for one edge; returns 1 time unit after the accept edge
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    alu_op   = op;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic base_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_res"}, result, exp);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Long op: result expected 32 edges after accept, busy high for 32 samples
  task automatic run_long(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic stall);
    int lat, busy_n;
    logic got;
    issue(op, a, b);
    src1 = $urandom;
    src2 = $urandom;
    if (stall) out_ready = 1'b0;
    lat = 0; busy_n = 0; got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      if (busy) busy_n++;
      @(posedge clk);
      #1;
      lat = k;
      if (out_valid) got = 1'b1;
    end
    check({tag, "_lat"}, 32'(lat), 32'd32);
    check({tag, "_res"}, result, exp);
    check({tag, "_busycyc"}, 32'(busy_n), 32'd32);
  endtask

  initial begin
    int ov_seen;
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    alu_op = '0; src1 = '0; src2 = '0;
    pcadd4 = 32'h0000_1004; csr_src = 32'hCAFE_F00D;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    base_op("add", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    @(posedge clk); #1;
    check("add_release", 32'(out_valid), 32'd0);
    base_op("sra", OP_SRA, 32'h8000_0000, 32'd36, 32'hF800_0000);
    base_op("srl", OP_SRL, 32'h8000_0000, 32'd36, 32'h0800_0000);
    base_op("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    base_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    base_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
    base_op("lui", OP_LUI, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000);
    base_op("jalr", OP_JALR, 32'h1, 32'h2, 32'h0000_1004);
    base_op("csr", OP_CSR, 32'h1, 32'h2, 32'hCAFE_F00D);
    base_op("undef", 5'd21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

    run_long("mul", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_long("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    run_long("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_long("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    base_op("div_by0", OP_DIV, 32'd7, 32'd0, 32'hFFFF_FFFF);
    base_op("rem_by0", OP_REM, 32'd7, 32'd0, 32'd7);
    base_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    base_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    run_long("divu", OP_DIVU, 32'd100, 32'd3, 32'd33, 1'b0);
    run_long("remu", OP_REMU, 32'd100, 32'd3, 32'd1, 1'b0);
    run_long("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    run_long("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_res", result, 32'hFFFF_FFFF);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    alu_op = OP_ADD; src1 = 32'd2; src2 = 32'd3; in_valid = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_res", result, 32'd5);

    // Flush in cycle T+10 of a DIVU; a competing op in that cycle is dropped
    issue(OP_DIVU, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    alu_op = OP_ADD; src1 = 32'd1; src2 = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd0);
    ov_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    check("flush_quiet", 32'(ov_seen), 32'd0);

    // Same run aborted by an asynchronous reset pulse
    issue(OP_DIVU, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ov_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) ov_seen++;
    end
    check("arst_quiet", 32'(ov_seen), 32'd0);
    check("arst_in_ready2", 32'(in_ready), 32'd1);
    base_op("post_rst_add", OP_ADD, 32'd10, 32'd20, 32'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised execute-stage ALU that adds the RV32M multiply/divide family to the base integer and CSR/LUI/JALR pass-through operations. Base operations complete in one registered cycle; multiply and divide run on an iterative engine that takes XLEN cycles. A valid/ready handshake on both sides lets the EX stage stall the pipeline while a long operation is in flight. It replaces the purely combinational ALU in the EX stage, and its result feeds the EX/MEM register.

## Interface
- `XLEN`, default 32: operand/result width; must be ≥ 8 and a power of two.
- `SHW`, default `$clog2(XLEN)`: shift-amount width (derived, not overridden).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation presented.
- `in_ready` out 1: operation accepted on `in_valid && in_ready`.
- `alu_op` in 5: operation code (package enum).
- `src1`, `src2` in XLEN: operands.
- `pcadd4` in XLEN: link value for the JALR op.
- `csr_src` in XLEN: value for the CSR op.
- `flush` in 1: abort the in-flight op; discard its result.
- `out_valid` out 1: `result` valid.
- `out_ready` in 1: consumer takes the result.
- `result` out XLEN: registered result.
- `busy` out 1: the iterative engine is active.

## Operation
- **Ops 0–12 (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, JALR, CSR)**
  - Semantics as in the base ALU.
  - Shifts use `src2[SHW-1:0]`.
  - SRA is a true arithmetic shift.
  - LUI returns `src2`, JALR returns `pcadd4`, CSR returns `csr_src`.
- **Ops 13–20 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)**
  - Follow the RISC-V M spec.
  - MULHSU treats `src1` as signed and `src2` as unsigned.
- **Undefined `alu_op`**: result 0, latency 1.
- **FSM states**:
  - IDLE → DONE on accepting a base op.
  - IDLE → DONE on accepting a DIV/REM special case.
  - IDLE → MUL or DIV on accepting any other M op.
  - MUL/DIV → DONE when the iteration counter reaches XLEN.
  - DONE → IDLE on `out_ready` when there is no new accept.
  - DONE → next state on `out_ready && in_valid` (back-to-back accept).
  - Any state → IDLE on `flush`.
- **Multiply datapath**
  - Operands are converted to magnitudes.
  - Radix-2 shift-add over XLEN iterations into a 2·XLEN product.
  - The product is negated if the operand signs differ (per signedness of the op).
  - MUL returns the low half; the MULH variants return the high half.
- **Divide datapath**
  - Restoring division on magnitudes, XLEN iterations.
  - Quotient sign = sign(src1) ^ sign(src2); remainder sign = sign(src1).
- **DIV/REM special cases (resolved in 1 cycle, no iteration)**
  - Divisor 0: quotient all-ones, remainder = `src1`.
  - Signed overflow (most-negative / −1): quotient = `src1`, remainder 0.
- **Operand capture**: operands and op are latched at accept. Input changes afterwards are ignored.

## Timing
- **Reset values**: all outputs are 0, except `in_ready` = 1. FSM goes to IDLE and the counter to 0.
- **`in_ready`**: `(state==IDLE) || (state==DONE && out_ready)`.
- **Latency** (accept at edge T):
  - Base op or special case: `out_valid` at T+1.
  - MUL/DIV family: `out_valid` at T+XLEN+1.
- **Output hold**: while `out_valid && !out_ready`, `result` and `out_valid` are held and `in_ready` = 0.
- **`busy`**: high exactly in the MUL/DIV states.
- **Counter**: width `SHW+1`; cleared on accept and on `flush`.
- **`flush`**:
  - Synchronous; highest priority over accept and completion.
  - Next cycle: state IDLE, `out_valid` = 0, `in_ready` = 1.
  - `in_valid` in the flush cycle is not accepted.
- **Async reset mid-operation** aborts immediately; no stale `out_valid` after `rst_n` rises.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` enum (5 bits, values 0–20).
  - `state_e`.
  - Helpers: `is_muldiv(op)` and `is_signed_src1/src2(op)`.
- Sub-module `muldiv_iter`: holds the shift-add/restoring engine, counter, and sign fix-up. Interface: start/op/operands in, done/result out.
- Base ops stay inline in `alu_muldiv`.

## Test plan
All scenarios at XLEN=32.
- **ADD**: 0x7FFFFFFF + 0x00000001 → 0x80000000. `out_valid` at T+1; `busy` never asserts.
- **SRA**: 0x80000000 by `src2` = 36 (low 5 bits = 4) → 0xF8000000. SRL of the same operands → 0x08000000.
- **Multiply high halves**: 0xFFFFFFFF × 0xFFFFFFFF → MUL 0x00000001, MULH 0x00000000, MULHU 0xFFFFFFFE, MULHSU 0xFFFFFFFF. Each result at T+33; `busy` high for 32 cycles.
- **Divide special cases**:
  - DIV 7/0 → 0xFFFFFFFF; REM 7/0 → 7.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - All at T+1.
- **Signed divide with backpressure**: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF. Result at T+33. Holding `out_ready` low for 3 cycles keeps `result` stable and `in_ready` low; then a back-to-back ADD is accepted on the release cycle.
- **Flush and reset aborts**:
  - DIVU 100/3 flushed at T+10: `out_valid` never asserts, `in_ready` = 1 at T+11.
  - A repeated run with `rst_n` pulsed low at T+10 gives identical quiescence.
